// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL slave backed by a small word-addressed RAM window.
// One response buffer: a new request is accepted whenever the held response drains in the same cycle.
module tl_ul_ram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          DEPTH     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [1:0]  a_size,
    input  logic [2:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [1:0]  d_size,
    output logic [2:0]  d_source,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t             state;
    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic               a_fire;
    logic               is_get;
    logic               is_put;
    logic               in_range;
    logic               misaligned;
    logic               denied;
    logic               do_write;
    logic               unused_param;

    assign unused_param = ^a_param;

    assign d_valid = (state == RESP);
    assign a_ready = (state == IDLE) || d_ready;
    assign d_param = 2'd0;
    assign a_fire  = a_valid && a_ready;

    // Decode of the incoming request; everything here is evaluated in the A-fire cycle.
    assign idx      = a_address[IDX_W+1:2];
    assign in_range = (a_address[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    assign is_get   = (a_opcode == OP_GET);
    assign is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);

    always_comb begin
        misaligned = 1'b0;
        case (a_size)
            2'd1:    misaligned = a_address[0];
            2'd2:    misaligned = |a_address[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign denied   = !(is_get || is_put) || !in_range || (a_size == 2'd3) || misaligned;
    assign do_write = a_fire && is_put && !denied;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            d_opcode  <= 3'd0;
            d_size    <= 2'd0;
            d_source  <= 3'd0;
            d_denied  <= 1'b0;
            d_data    <= 32'd0;
            d_corrupt <= 1'b0;
            // NOTE: storage must read back as zero after reset, so the array is cleared here
            // rather than left uninitialised; this keeps it in flops instead of a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            if (a_fire) begin
                state     <= RESP;
                d_opcode  <= is_get ? OP_ACK_DATA : OP_ACK;
                d_size    <= a_size;
                d_source  <= a_source;
                d_denied  <= denied;
                d_data    <= (is_get && !denied) ? mem[idx] : 32'd0;
                d_corrupt <= is_get && denied;
            end else if (d_valid && d_ready) begin
                state <= IDLE;
            end

            // A following Get reads the array after this edge, so Put-then-Get ordering is natural.
            if (do_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (a_mask[b]) begin
                        mem[idx][8*b +: 8] <= a_data[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_tl_ul_ram_responder;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [2:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [2:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    tl_ul_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [2:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } resp_t;

    logic [31:0] ref_mem [DEPTH];
    resp_t       exp_resp;
    logic        exp_valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Transaction-level model: decides the response from the address-map and alignment rules.
    task automatic model_request();
        logic supported, in_range, aligned, den;
        int   word;
        supported = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
        in_range  = (a_address >= BASE) && (a_address < BASE + DEPTH * 4);
        aligned   = (a_size == 2'd3) ? 1'b0 : ((a_address % (32'd1 << a_size)) == 0);
        den       = !supported || !in_range || (a_size > 2) || !aligned;
        word      = int'((a_address - BASE) / 4);
        exp_resp.opcode  = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
        exp_resp.size    = a_size;
        exp_resp.source  = a_source;
        exp_resp.denied  = den;
        exp_resp.corrupt = (a_opcode == 3'd4) && den;
        exp_resp.data    = (!den && a_opcode == 3'd4) ? ref_mem[word] : 32'd0;
        if (!den && a_opcode != 3'd4) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) ref_mem[word][8*b +: 8] = a_data[8*b +: 8];
            end
        end
    endtask

    // One clock: inputs are already driven; outputs are compared at the following falling edge.
    task automatic do_cycle();
        logic exp_ready;
        #1;
        exp_ready = !exp_valid || d_ready;
        if (reset) begin
            exp_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        end else begin
            check("a_ready", a_ready, exp_ready);
            if (a_valid && exp_ready) begin
                model_request();
                exp_valid = 1'b1;
            end else if (exp_valid && d_ready) begin
                exp_valid = 1'b0;
            end
        end
        @(negedge clock);
        check("d_valid", d_valid, exp_valid);
        if (exp_valid) begin
            check("d_opcode",  d_opcode,  exp_resp.opcode);
            check("d_param",   d_param,   2'd0);
            check("d_size",    d_size,    exp_resp.size);
            check("d_source",  d_source,  exp_resp.source);
            check("d_denied",  d_denied,  exp_resp.denied);
            check("d_data",    d_data,    exp_resp.data);
            check("d_corrupt", d_corrupt, exp_resp.corrupt);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [1:0] size, input logic [2:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic dr);
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_param = 3'($urandom);
        d_ready = dr;
        do_cycle();
        a_valid = 1'b0;
    endtask

    task automatic idle(input logic dr);
        a_valid = 1'b0;
        d_ready = dr;
        do_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d_valid"},   d_valid,   1'b0);
        check({tag, "_a_ready"},   a_ready,   1'b1);
        check({tag, "_d_opcode"},  d_opcode,  3'd0);
        check({tag, "_d_size"},    d_size,    2'd0);
        check({tag, "_d_source"},  d_source,  3'd0);
        check({tag, "_d_data"},    d_data,    32'd0);
        check({tag, "_d_denied"},  d_denied,  1'b0);
        check({tag, "_d_corrupt"}, d_corrupt, 1'b0);
    endtask

    initial begin
        logic [31:0] held;
        exp_valid = 1'b0;
        reset = 1'b1; a_valid = 1'b0; d_ready = 1'b1; a_opcode = 3'd0; a_param = 3'd0;
        a_size = 2'd0; a_source = 3'd0; a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0;
        do_cycle();
        do_cycle();
        check_reset_outputs("rst");
        reset = 1'b0;

        // Get after reset returns zero.
        req(3'd4, 2'd2, 3'd5, 32'h2004, 4'hF, 32'd0, 1'b1);
        check("get0_valid",  d_valid,  1'b1);
        check("get0_opcode", d_opcode, 3'd1);
        check("get0_source", d_source, 3'd5);
        check("get0_data",   d_data,   32'd0);
        check("get0_denied", d_denied, 1'b0);

        // Full write, partial byte update, read back merged word.
        req(3'd0, 2'd2, 3'd1, 32'h2008, 4'hF, 32'hDEAD_BEEF, 1'b1);
        req(3'd1, 2'd2, 3'd2, 32'h2008, 4'h2, 32'h0000_1100, 1'b1);
        req(3'd4, 2'd2, 3'd3, 32'h2008, 4'hF, 32'd0, 1'b1);
        check("merge_data", d_data, 32'hDEAD_11EF);

        // Out-of-range Get, unsupported opcode, storage untouched.
        req(3'd4, 2'd2, 3'd4, 32'h3000, 4'hF, 32'd0, 1'b1);
        check("oor_opcode",  d_opcode,  3'd1);
        check("oor_denied",  d_denied,  1'b1);
        check("oor_corrupt", d_corrupt, 1'b1);
        check("oor_data",    d_data,    32'd0);
        req(3'd2, 2'd2, 3'd6, 32'h2000, 4'hF, 32'hFFFF_FFFF, 1'b1);
        check("badop_opcode",  d_opcode,  3'd0);
        check("badop_denied",  d_denied,  1'b1);
        check("badop_corrupt", d_corrupt, 1'b0);
        req(3'd4, 2'd2, 3'd7, 32'h2000, 4'hF, 32'd0, 1'b1);
        check("badop_nowrite", d_data, 32'd0);

        // Back-pressure: response held with requests waiting, then drain and accept together.
        req(3'd4, 2'd2, 3'd1, 32'h2008, 4'hF, 32'd0, 1'b1);
        held = d_data;
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 2'd2; a_source = 3'd2;
        a_address = 32'h200C; a_mask = 4'hF; a_data = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            d_ready = 1'b0;
            do_cycle();
            check("stall_a_ready", a_ready, 1'b0);
            check("stall_data",    d_data,  held);
            check("stall_source",  d_source, 3'd1);
        end
        d_ready = 1'b1;
        do_cycle();
        check("swap_valid",  d_valid,  1'b1);
        check("swap_source", d_source, 3'd2);
        check("swap_opcode", d_opcode, 3'd0);
        a_valid = 1'b0;
        req(3'd4, 2'd2, 3'd0, 32'h200C, 4'hF, 32'd0, 1'b1);
        check("swap_written", d_data, 32'hCAFE_F00D);

        // Alignment rules.
        req(3'd4, 2'd2, 3'd1, 32'h2002, 4'hF, 32'd0, 1'b1);
        check("mis_w_denied", d_denied, 1'b1);
        req(3'd4, 2'd1, 3'd1, 32'h2002, 4'hF, 32'd0, 1'b1);
        check("mis_h_denied", d_denied, 1'b0);
        idle(1'b1);

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 1500; n++) begin
            int r;
            a_valid  = ($urandom_range(0, 3) != 0);
            d_ready  = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            a_opcode = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r < 5) ? 3'd4 : 3'($urandom);
            a_size   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            a_address = (r < 8) ? BASE + 32'($urandom_range(0, DEPTH * 4 - 1))
                      : (r == 8) ? 32'h3000 + 32'($urandom_range(0, 63)) : 32'($urandom);
            a_source = 3'($urandom);
            a_mask   = 4'($urandom);
            a_data   = $urandom;
            a_param  = 3'($urandom);
            do_cycle();
        end
        a_valid = 1'b0;
        idle(1'b1);

        // Reset while a response is stalled discards it and clears storage.
        req(3'd0, 2'd2, 3'd1, 32'h2010, 4'hF, 32'h1234_5678, 1'b1);
        req(3'd4, 2'd2, 3'd2, 32'h2010, 4'hF, 32'd0, 1'b1);
        check("pre_rst_data", d_data, 32'h1234_5678);
        idle(1'b0);
        check("pre_rst_valid", d_valid, 1'b1);
        reset = 1'b1;
        idle(1'b0);
        check_reset_outputs("rst2");
        reset = 1'b0;
        for (int w = 0; w < DEPTH; w++) begin
            req(3'd4, 2'd2, 3'($urandom), BASE + 32'(w * 4), 4'hF, 32'd0, 1'b1);
            check("rst_clear", d_data, 32'd0);
        end
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
